eight_bit_subtract_unit: RTL and testbench

Sequential 8-bit subtractor for the ALU: computes b − c as b + ~c + 1, one bit per clock, LSB first, so the borrow ripples the way the relay ALU's carry chain does. Sits beside the adder unit, driven by the sequencer with a start/busy/done handshake. Outputs are a registered difference, a borrow flag and a zero flag, all held until the next accepted start.

---
 rtl/eight_bit_subtract_unit_pkg.sv | 24 ++
 rtl/eight_bit_subtract_unit_if.sv | 37 +++
 rtl/eight_bit_subtract_unit_bit_cell.sv | 19 +
 rtl/eight_bit_subtract_unit.sv | 116 +++++++++++
 tb/tb_eight_bit_subtract_unit.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/eight_bit_subtract_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg: definitions shared by the ALU subtract unit and its interface.
//   alu_state_e : sequencer states of the bit-serial subtractor
//   ALU_WIDTH   : default operand/result width
//   ALU_IDX_W   : bit-index counter width for the default width
//   idx_w()     : bit-index counter width for an arbitrary width
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_IDX_W = $clog2(ALU_WIDTH);

  // Never narrower than one bit, so a degenerate width still elaborates.
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/eight_bit_subtract_unit_if.sv
// ---------------------------------------------------------------------------
// eight_bit_subtract_unit_if: start/busy/done handshake between the ALU
// sequencer (master) and the bit-serial subtractor (slave).
//   start      : request, sampled only while the unit is idle
//   b, c       : minuend / subtrahend
//   borrow_in  : incoming borrow (only when SUB_BORROW_IN_EN is defined)
//   busy, done : operation in progress / one-cycle result-valid pulse
//   diff_out, borrow, zero : registered result and flags
// Optional feature macro: SUB_BORROW_IN_EN
// ---------------------------------------------------------------------------
interface eight_bit_subtract_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
`ifdef SUB_BORROW_IN_EN
  logic             borrow_in;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff_out;
  logic             borrow;
  logic             zero;

`ifdef SUB_BORROW_IN_EN
  modport master (output start, b, c, borrow_in,
                  input  busy, done, diff_out, borrow, zero);
  modport slave  (input  start, b, c, borrow_in,
                  output busy, done, diff_out, borrow, zero);
`else
  modport master (output start, b, c,
                  input  busy, done, diff_out, borrow, zero);
  modport slave  (input  start, b, c,
                  output busy, done, diff_out, borrow, zero);
`endif
endinterface

// File: rtl/eight_bit_subtract_unit_bit_cell.sv
// ---------------------------------------------------------------------------
// sub_bit_cell: combinational one-bit full adder used as the subtractor's
// single reusable bit slice (subtrahend bit arrives already inverted).
//   a    : minuend bit
//   b_n  : inverted subtrahend bit
//   cin  : carry in (1 = no borrow)
//   s    : difference bit
//   cout : carry out (0 = borrow)
// ---------------------------------------------------------------------------
module sub_bit_cell (
  input  logic a,
  input  logic b_n,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b_n ^ cin;
  assign cout = (a & b_n) | (a & cin) | (b_n & cin);
endmodule

// File: rtl/eight_bit_subtract_unit.sv
// ---------------------------------------------------------------------------
// eight_bit_subtract_unit: bit-serial subtractor, b - c computed as
// b + ~c + 1, one bit per clock, LSB first, through a single bit cell.
//   clock : rising-edge clock
//   reset : synchronous active-high reset, overrides everything
//   bus   : eight_bit_subtract_unit_if.slave (start/b/c[/borrow_in] in,
//           busy/done/diff_out/borrow/zero out)
// Optional feature macro: SUB_BORROW_IN_EN -- adds borrow_in; the initial
// carry becomes ~borrow_in so bytes can be chained.
// Result and flags change only on the DONE-entry edge or on reset.
// ---------------------------------------------------------------------------
module eight_bit_subtract_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  eight_bit_subtract_unit_if.slave bus
);

  localparam int IDX_W = idx_w(WIDTH);

  alu_state_e         r_state;
  alu_state_e         w_state_nxt;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_c_sr;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               r_zero;

  logic               w_s;
  logic               w_cout;
  logic               w_last;
  logic               w_accept;
  logic               w_carry_init;
  logic [WIDTH-1:0]   w_res_full;

  sub_bit_cell u_cell (
    .a    (r_b_sr[0]),
    .b_n  (~r_c_sr[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

`ifdef SUB_BORROW_IN_EN
  assign w_carry_init = ~bus.borrow_in;
`else
  assign w_carry_init = 1'b1;
`endif

  assign w_last     = (r_idx == IDX_W'(WIDTH - 1));
  assign w_accept   = (r_state == IDLE) && bus.start;
  // Result as it stands after this edge's bit lands in the MSB.
  assign w_res_full = {w_s, r_res[WIDTH-1:1]};

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nxt = SHIFT;
      SHIFT:   if (w_last)    w_state_nxt = DONE;
      DONE:                   w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Bit-serial datapath and registered result
  always_ff @(posedge clock) begin
    if (reset) begin
      r_b_sr   <= '0;
      r_c_sr   <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_b_sr  <= bus.b;
      r_c_sr  <= bus.c;
      r_res   <= '0;
      r_carry <= w_carry_init;
      r_idx   <= '0;
    end else if (r_state == SHIFT) begin
      r_b_sr  <= r_b_sr >> 1;
      r_c_sr  <= r_c_sr >> 1;
      r_res   <= w_res_full;
      r_carry <= w_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        // Final carry of 1 means no borrow occurred.
        r_diff   <= w_res_full;
        r_borrow <= ~w_cout;
        r_zero   <= (w_res_full == '0);
      end
    end
  end

  assign bus.busy     = (r_state == SHIFT);
  assign bus.done     = (r_state == DONE);
  assign bus.diff_out = r_diff;
  assign bus.borrow   = r_borrow;
  assign bus.zero     = r_zero;

endmodule

// File: tb/tb_eight_bit_subtract_unit.sv
module tb_eight_bit_subtract_unit;

  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  eight_bit_subtract_unit_if #(.WIDTH(W)) bus ();

  eight_bit_subtract_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: plain modular arithmetic on integers.
  task automatic model(input int b, input int c, input int bi,
                       output logic [7:0] d, output logic bo, output logic z);
    int r;
    r  = b - c - bi;
    d  = 8'(r & 255);
    bo = (b < c + bi);
    z  = ((r & 255) == 0);
  endtask

  // glitch: 1 = pulse start with 0xFF/0x00 on SHIFT cycle 3
  task automatic run_op(input string tag, input int b, input int c, input int bi,
                        input bit glitch);
    logic [7:0] ed, prev;
    logic       eb, ez;
    int cnt, busy_cnt, extra_done;
    model(b, c, bi, ed, eb, ez);
    prev = bus.diff_out;
    @(negedge clock);
    bus.start = 1'b1; bus.b = 8'(b); bus.c = 8'(c);
`ifdef SUB_BORROW_IN_EN
    bus.borrow_in = bi[0];
`endif
    @(negedge clock);
    bus.start = 1'b0;
    bus.b = 8'($urandom_range(0, 255)); bus.c = 8'($urandom_range(0, 255));
    busy_cnt = bus.busy ? 1 : 0;
    cnt = 0;
    while (!bus.done && cnt < 20) begin
      @(negedge clock);
      cnt++;
      if (bus.busy) busy_cnt++;
      if (glitch && cnt == 3) begin
        bus.start = 1'b1; bus.b = 8'hFF; bus.c = 8'h00;
      end else begin
        bus.start = 1'b0;
      end
      if (cnt == 4) check({tag, "_hold"}, 32'(bus.diff_out), 32'(prev));
    end
    bus.start = 1'b0;
    check({tag, "_lat"},    32'(cnt), 32'(W));
    check({tag, "_busy"},   32'(busy_cnt), 32'(W));
    check({tag, "_diff"},   32'(bus.diff_out), 32'(ed));
    check({tag, "_borrow"}, 32'(bus.borrow), 32'(eb));
    check({tag, "_zero"},   32'(bus.zero), 32'(ez));
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.done) extra_done++;
    end
    check({tag, "_onepulse"}, 32'(extra_done), 32'd0);
    check({tag, "_keep"},     32'(bus.diff_out), 32'(ed));
  endtask

  initial begin
    int dones;
    bus.start = 1'b0; bus.b = '0; bus.c = '0;
`ifdef SUB_BORROW_IN_EN
    bus.borrow_in = 1'b0;
`endif
    // Reset together with start: start must be lost.
    repeat (2) @(negedge clock);
    bus.start = 1'b1; bus.b = 8'h12; bus.c = 8'h01;
    @(negedge clock);
    bus.start = 1'b0;
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_diff",   32'(bus.diff_out), 32'd0);
    check("rst_borrow", 32'(bus.borrow), 32'd0);
    check("rst_zero",   32'(bus.zero), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_busy", 32'(bus.busy), 32'd0);

    run_op("t5a3c", 8'h5A, 8'h3C, 0, 1'b0);
    run_op("t1020", 8'h10, 8'h20, 0, 1'b0);
    run_op("t7777", 8'h77, 8'h77, 0, 1'b0);
    run_op("t0100", 8'h01, 8'h00, 0, 1'b0);
    run_op("t0001", 8'h00, 8'h01, 0, 1'b0);
    run_op("tign",  8'h5A, 8'h3C, 0, 1'b1);

    // Reset on SHIFT cycle 4 aborts the operation.
    @(negedge clock);
    bus.start = 1'b1; bus.b = 8'h40; bus.c = 8'h01;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy",   32'(bus.busy), 32'd0);
    check("abort_done",   32'(bus.done), 32'd0);
    check("abort_diff",   32'(bus.diff_out), 32'd0);
    check("abort_borrow", 32'(bus.borrow), 32'd0);
    check("abort_zero",   32'(bus.zero), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (bus.done || bus.busy) dones++;
    end
    check("abort_nodone", 32'(dones), 32'd0);
    run_op("t0301", 8'h03, 8'h01, 0, 1'b0);

`ifdef SUB_BORROW_IN_EN
    run_op("bi1", 8'h00, 8'h00, 1, 1'b0);
    run_op("bi0", 8'h00, 8'h00, 0, 1'b0);
`endif

    for (int k = 0; k < 16; k++) begin
      int rb, rc, rbi;
      rb  = int'($urandom_range(0, 255));
      rc  = int'($urandom_range(0, 255));
      rbi = 0;
`ifdef SUB_BORROW_IN_EN
      rbi = int'($urandom_range(0, 1));
`endif
      run_op($sformatf("rnd%0d", k), rb, rc, rbi, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
